sram_lsu: RTL and testbench

Load/store initiator for the byte-addressed 64 KiB SRAM. It accepts byte, halfword and word load/store requests from the core over a valid/ready handshake. It drives the SRAM `wen`/`addr`/`wdata` port, captures `rdata`, zero- or sign-extends it, and returns read data over a backpressured response channel. Reads may be bursts of 1–16 beats at consecutive element addresses.

---
 rtl/sram_lsu_if.sv | 53 +++++
 rtl/sram_lsu.sv | 169 ++++++++++++++++
 tb/tb_sram_lsu.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_lsu_if.sv
// Purpose: bundles the core request/response channels and the SRAM port of the load/store unit.
// Latency: none; wiring only.
// Backpressure: req_valid/req_ready on requests, rsp_valid/rsp_ready on load beats; SRAM port is unflowcontrolled.
//
// Ports (seen from the LSU, modport slave):
//   req_*   : request from the core (valid/ready, store flag, size, signed, address, store data, burst length)
//   rsp_*   : load data beats back to the core (valid/ready, extended data, last-beat flag)
//   wr_done : one-cycle pulse during the SRAM write cycle of a store
//   sram_*  : SRAM write enables, address, write data, combinational read data
interface sram_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_len;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_last;

    logic        wr_done;

    logic [3:0]  sram_wen;
    logic [15:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    // LSU side
    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, req_len,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_last,
        input  rsp_ready,
        output wr_done,
        output sram_wen, sram_addr, sram_wdata,
        input  sram_rdata
    );

    // Core/SRAM side
    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, req_len,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_last,
        output rsp_ready,
        input  wr_done,
        input  sram_wen, sram_addr, sram_wdata,
        output sram_rdata
    );
endinterface

// File: rtl/sram_lsu.sv
// Purpose: byte/half/word load-store initiator for the 64 KiB SRAM, with 1-16 beat load bursts.
// Latency: store writes the SRAM one edge after accept; each load beat is valid one edge after its READ cycle (2 cycles/beat).
// Backpressure: req_ready only in IDLE; rsp_ready low holds the current beat stable in RESP indefinitely.
//
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : sram_lsu_if.slave - request, response, wr_done and SRAM port
//
// Every output is a register or a decode of the state register (plus latched
// request fields), so there is no combinational path from req_* or rsp_ready.
module sram_lsu (
    input  logic       clk,
    input  logic       rst,
    sram_lsu_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // Latched request fields. The store/load flag is not kept: it is encoded
    // by the choice of WRITE vs READ at accept time.
    logic [1:0]  size_q;
    logic        sgn_q;
    logic [15:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  cnt_q;      // remaining beats after the current one

    logic [31:0] rdata_q;
    logic        last_q;

    // Byte-lane write enables for a store of the latched size (size 11 = word).
    function automatic logic [3:0] size_mask(input logic [1:0] sz);
        logic [3:0] m;
        case (sz)
            2'b00:   m = 4'b0001;
            2'b01:   m = 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    // Element stride for burst address advance.
    function automatic logic [15:0] size_step(input logic [1:0] sz);
        logic [15:0] s;
        case (sz)
            2'b00:   s = 16'd1;
            2'b01:   s = 16'd2;
            default: s = 16'd4;
        endcase
        return s;
    endfunction

    // Right-aligned load data with zero or sign extension; words pass through.
    function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] sz,
                                           input logic sgn);
        logic [31:0] r;
        case (sz)
            2'b00:   r = {{24{sgn & d[7]}},  d[7:0]};
            2'b01:   r = {{16{sgn & d[15]}}, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    state_nxt = bus.req_we ? WRITE : READ;
                end
            end
            WRITE: begin
                // single write cycle per store
                state_nxt = IDLE;
            end
            READ: begin
                state_nxt = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt = (cnt_q == 4'd0) ? IDLE : READ;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            size_q  <= 2'b00;
            sgn_q   <= 1'b0;
            addr_q  <= 16'h0000;
            wdata_q <= 32'h0000_0000;
            cnt_q   <= 4'd0;
            rdata_q <= 32'h0000_0000;
            last_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        size_q  <= bus.req_size;
                        sgn_q   <= bus.req_signed;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        // a store ignores req_len; clear the counter so no stale burst state lingers
                        cnt_q   <= bus.req_we ? 4'd0 : bus.req_len;
                    end
                end
                READ: begin
                    rdata_q <= extend(bus.sram_rdata, size_q, sgn_q);
                    last_q  <= (cnt_q == 4'd0);
                end
                RESP: begin
                    // advance only when the beat is consumed and more remain;
                    // the address stays put while the consumer stalls
                    if (bus.rsp_ready && (cnt_q != 4'd0)) begin
                        addr_q <= addr_q + size_step(size_q);
                        cnt_q  <= cnt_q - 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.req_ready  = (state == IDLE);
    assign bus.rsp_valid  = (state == RESP);
    assign bus.rsp_rdata  = rdata_q;
    assign bus.rsp_last   = last_q;
    assign bus.wr_done    = (state == WRITE);

    // Write enables are gated by state so an async reset in WRITE kills them at once.
    assign bus.sram_wen   = (state == WRITE) ? size_mask(size_q) : 4'b0000;
    assign bus.sram_addr  = addr_q;
    assign bus.sram_wdata = wdata_q;

endmodule

// File: tb/tb_sram_lsu.sv
// Bench for sram_lsu: byte-addressed SRAM model, directed request table, bursts, stalls and resets.
module tb_sram_lsu;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;

    always #5 clk = ~clk;

    sram_lsu_if bus();

    sram_lsu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 64 KiB byte-addressed SRAM, combinational read, little-endian lanes, 16-bit wrap.
    logic [7:0] mem [0:65535];

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (bus.sram_wen[i]) mem[bus.sram_addr + 16'(i)] = bus.sram_wdata[8*i +: 8];
            end
        end
    end

    assign bus.sram_rdata = {mem[bus.sram_addr + 16'd3], mem[bus.sram_addr + 16'd2],
                             mem[bus.sram_addr + 16'd1], mem[bus.sram_addr]};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Presents one request at a negedge in IDLE; returns at the negedge of the cycle after accept.
    task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [15:0] a, input logic [31:0] wd, input logic [3:0] len);
        chk("req_ready before request", 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.req_len    = len;
        @(negedge clk);
        bus.req_valid  = 1'b0;
        bus.req_wdata  = 32'h0;
    endtask

    task automatic do_store(input logic [1:0] sz, input logic [15:0] a, input logic [31:0] wd,
                            input logic [3:0] exp_wen);
        issue(1'b1, sz, 1'b0, a, wd, 4'd0);
        chk("store wen", 32'(bus.sram_wen), 32'(exp_wen));
        chk("store addr", 32'(bus.sram_addr), 32'(a));
        chk("store wdata", bus.sram_wdata, wd);
        chk("store wr_done", 32'(bus.wr_done), 32'd1);
        chk("store req_ready busy", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        chk("store wen after write", 32'(bus.sram_wen), 32'd0);
        chk("store wr_done after write", 32'(bus.wr_done), 32'd0);
    endtask

    task automatic do_load(input logic [1:0] sz, input logic sg, input logic [15:0] a,
                           input logic [31:0] exp);
        issue(1'b0, sz, sg, a, 32'h0, 4'd0);
        chk("load read-cycle rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("load read-cycle addr", 32'(bus.sram_addr), 32'(a));
        chk("load read-cycle wen", 32'(bus.sram_wen), 32'd0);
        @(negedge clk);
        chk("load rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("load rsp_rdata", bus.rsp_rdata, exp);
        chk("load rsp_last", 32'(bus.rsp_last), 32'd1);
        @(negedge clk);
        chk("load rsp_valid after accept", 32'(bus.rsp_valid), 32'd0);
    endtask

    logic [31:0] exp_beats [16];
    logic [15:0] exp_addrs [16];

    // Burst load with rsp_ready high except for stall_cyc extra cycles on beat stall_beat.
    task automatic run_burst(input logic [1:0] sz, input logic sg, input logic [15:0] a,
                             input int len, input int stall_beat, input int stall_cyc);
        issue(1'b0, sz, sg, a, 32'h0, 4'(len));
        for (int k = 0; k <= len; k++) begin
            chk("burst read rsp_valid", 32'(bus.rsp_valid), 32'd0);
            chk("burst read addr", 32'(bus.sram_addr), 32'(exp_addrs[k]));
            chk("burst read req_ready", 32'(bus.req_ready), 32'd0);
            @(negedge clk);
            chk("burst rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("burst rsp_rdata", bus.rsp_rdata, exp_beats[k]);
            chk("burst rsp_last", 32'(bus.rsp_last), (k == len) ? 32'd1 : 32'd0);
            chk("burst resp req_ready", 32'(bus.req_ready), 32'd0);
            if (k == stall_beat) begin
                bus.rsp_ready = 1'b0;
                for (int s = 0; s < stall_cyc; s++) begin
                    @(negedge clk);
                    chk("stall rsp_valid", 32'(bus.rsp_valid), 32'd1);
                    chk("stall rsp_rdata", bus.rsp_rdata, exp_beats[k]);
                    chk("stall addr", 32'(bus.sram_addr), 32'(exp_addrs[k]));
                end
                bus.rsp_ready = 1'b1;
            end
            @(negedge clk);
        end
        chk("burst end rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("burst end req_ready", 32'(bus.req_ready), 32'd1);
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  exp_wen;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [23];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //            we    size   sgn   addr      wdata          wen      rdata
        vecs[0]  = '{1'b1, 2'b10, 1'b0, 16'h0010, 32'hDEADBEEF, 4'b1111, 32'h0};
        vecs[1]  = '{1'b0, 2'b10, 1'b0, 16'h0010, 32'h0,        4'b0000, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 2'b00, 1'b0, 16'h0021, 32'h00000080, 4'b0001, 32'h0};
        vecs[3]  = '{1'b0, 2'b00, 1'b1, 16'h0021, 32'h0,        4'b0000, 32'hFFFFFF80};
        vecs[4]  = '{1'b0, 2'b00, 1'b0, 16'h0021, 32'h0,        4'b0000, 32'h00000080};
        vecs[5]  = '{1'b1, 2'b01, 1'b0, 16'h0040, 32'h00008001, 4'b0011, 32'h0};
        vecs[6]  = '{1'b0, 2'b01, 1'b1, 16'h0040, 32'h0,        4'b0000, 32'hFFFF8001};
        vecs[7]  = '{1'b0, 2'b01, 1'b0, 16'h0040, 32'h0,        4'b0000, 32'h00008001};
        vecs[8]  = '{1'b1, 2'b11, 1'b0, 16'h0050, 32'h12345678, 4'b1111, 32'h0};
        vecs[9]  = '{1'b0, 2'b11, 1'b1, 16'h0050, 32'h0,        4'b0000, 32'h12345678};
        vecs[10] = '{1'b0, 2'b00, 1'b1, 16'h0051, 32'h0,        4'b0000, 32'h00000056};
        vecs[11] = '{1'b0, 2'b00, 1'b1, 16'h0010, 32'h0,        4'b0000, 32'hFFFFFFEF};
        vecs[12] = '{1'b0, 2'b01, 1'b1, 16'h0011, 32'h0,        4'b0000, 32'hFFFFADBE};
        vecs[13] = '{1'b1, 2'b00, 1'b0, 16'h0060, 32'hAABBCC7F, 4'b0001, 32'h0};
        vecs[14] = '{1'b0, 2'b10, 1'b0, 16'h0060, 32'h0,        4'b0000, 32'h0000007F};
        vecs[15] = '{1'b1, 2'b10, 1'b0, 16'h0100, 32'h00000001, 4'b1111, 32'h0};
        vecs[16] = '{1'b1, 2'b10, 1'b0, 16'h0104, 32'h00000002, 4'b1111, 32'h0};
        vecs[17] = '{1'b1, 2'b10, 1'b0, 16'h0108, 32'h00000003, 4'b1111, 32'h0};
        vecs[18] = '{1'b1, 2'b10, 1'b0, 16'h010C, 32'h00000004, 4'b1111, 32'h0};
        vecs[19] = '{1'b1, 2'b00, 1'b0, 16'hFFFE, 32'h00000011, 4'b0001, 32'h0};
        vecs[20] = '{1'b1, 2'b00, 1'b0, 16'hFFFF, 32'h00000092, 4'b0001, 32'h0};
        vecs[21] = '{1'b1, 2'b00, 1'b0, 16'h0000, 32'h00000033, 4'b0001, 32'h0};
        vecs[22] = '{1'b0, 2'b10, 1'b0, 16'h0000, 32'h0,        4'b0000, 32'h00000033};

        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = 16'h0;
        bus.req_wdata  = 32'h0;
        bus.req_len    = 4'd0;
        bus.rsp_ready  = 1'b1;

        #1 clr = 1'b1;
        #1 clr = 1'b0;
        #1;
        chk("reset req_ready", 32'(bus.req_ready), 32'd1);
        chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("reset rsp_last", 32'(bus.rsp_last), 32'd0);
        chk("reset wr_done", 32'(bus.wr_done), 32'd0);
        chk("reset sram_wen", 32'(bus.sram_wen), 32'd0);
        chk("reset sram_addr", 32'(bus.sram_addr), 32'd0);
        chk("reset sram_wdata", bus.sram_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 23; v++) begin
            if (vecs[v].we) do_store(vecs[v].size, vecs[v].addr, vecs[v].wdata, vecs[v].exp_wen);
            else            do_load(vecs[v].size, vecs[v].sgn, vecs[v].addr, vecs[v].exp_rdata);
        end

        // four-beat word burst, no stall
        for (int k = 0; k < 4; k++) begin
            exp_beats[k] = 32'(k + 1);
            exp_addrs[k] = 16'h0100 + 16'(4 * k);
        end
        run_burst(2'b10, 1'b0, 16'h0100, 3, -1, 0);

        // same burst, consumer stalls 5 cycles on beat 2
        run_burst(2'b10, 1'b0, 16'h0100, 3, 1, 5);

        // signed byte burst wrapping past FFFF
        exp_beats[0] = 32'h00000011; exp_addrs[0] = 16'hFFFE;
        exp_beats[1] = 32'hFFFFFF92; exp_addrs[1] = 16'hFFFF;
        exp_beats[2] = 32'h00000033; exp_addrs[2] = 16'h0000;
        run_burst(2'b00, 1'b1, 16'hFFFE, 2, -1, 0);

        // reset in the WRITE cycle aborts the store
        issue(1'b1, 2'b10, 1'b0, 16'h0200, 32'hCAFEF00D, 4'd0);
        chk("pre-reset wen", 32'(bus.sram_wen), 32'hF);
        rst = 1'b1;
        #1;
        chk("write reset wen", 32'(bus.sram_wen), 32'd0);
        chk("write reset wr_done", 32'(bus.wr_done), 32'd0);
        chk("write reset req_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_load(2'b10, 1'b0, 16'h0200, 32'h00000000);

        // reset while beat 2 of a burst is waiting
        issue(1'b0, 2'b10, 1'b0, 16'h0100, 32'h0, 4'd3);
        @(negedge clk);
        chk("mid-burst beat1", bus.rsp_rdata, 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("mid-burst beat2 valid", 32'(bus.rsp_valid), 32'd1);
        chk("mid-burst beat2", bus.rsp_rdata, 32'd2);
        rst = 1'b1;
        #1;
        chk("burst reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("burst reset req_ready", 32'(bus.req_ready), 32'd1);
        chk("burst reset rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("burst reset rsp_last", 32'(bus.rsp_last), 32'd0);
        chk("burst reset wen", 32'(bus.sram_wen), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("post-reset no response", 32'(bus.rsp_valid), 32'd0);
        end
        do_load(2'b10, 1'b0, 16'h0104, 32'h00000002);
        do_store(2'b01, 16'h0300, 32'h0000BEEF, 4'b0011);
        do_load(2'b01, 1'b1, 16'h0300, 32'hFFFFBEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
